ex_stage_muldiv: RTL and testbench

- Execute stage directly downstream of the ID/EX pipeline register. Consumes its operand, immediate and control outputs.
- Computes single-cycle ALU results, plus the RV32M multiply/divide instructions through an iterative 32-step unit.
- Registers results and the memory/writeback controls into the EX/MEM boundary.
- Stalls the front end while a multi-cycle M-op is in progress.

---
 rtl/ex_stage_muldiv_if.sv | 40 ++++
 rtl/ex_stage_muldiv.sv | 162 ++++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_muldiv_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master: the pipeline side that drives ID/EX outputs and observes EX/MEM.
// slave:  the execute stage itself.
interface ex_stage_muldiv_if;
  logic [31:0] regData1_IDEX_out, regData2_IDEX_out, sext_imm_IDEX_out;
  logic        immSel_IDEX_out, PC_as_operand_IDEX_out;
  logic        setDataZero_IDEX_out, addConstant4_IDEX_out;
  logic [3:0]  ALU_op_IDEX_out;
  logic        memRead_IDEX_EXMEM, memWrite_IDEX_EXMEM;
  logic        regWriteEnable_IDEX_EXMEM, ECALL_IDEX_EXMEM;
  logic [2:0]  memType_IDEX_EXMEM;
  logic [31:0] instruction_IDEX_EXMEM, PC_IDEX_EXMEM;
  logic        flush_EX;
  logic        stall_EX;
  logic [31:0] aluResult_EXMEM, storeData_EXMEM, instruction_EXMEM, PC_EXMEM;
  logic        memRead_EXMEM, memWrite_EXMEM, regWriteEnable_EXMEM, ECALL_EXMEM;
  logic [2:0]  memType_EXMEM;

  modport master (
    output regData1_IDEX_out, regData2_IDEX_out, sext_imm_IDEX_out,
           immSel_IDEX_out, PC_as_operand_IDEX_out, setDataZero_IDEX_out,
           addConstant4_IDEX_out, ALU_op_IDEX_out, memRead_IDEX_EXMEM,
           memWrite_IDEX_EXMEM, regWriteEnable_IDEX_EXMEM, ECALL_IDEX_EXMEM,
           memType_IDEX_EXMEM, instruction_IDEX_EXMEM, PC_IDEX_EXMEM, flush_EX,
    input  stall_EX, aluResult_EXMEM, storeData_EXMEM, instruction_EXMEM,
           PC_EXMEM, memRead_EXMEM, memWrite_EXMEM, regWriteEnable_EXMEM,
           ECALL_EXMEM, memType_EXMEM
  );

  modport slave (
    input  regData1_IDEX_out, regData2_IDEX_out, sext_imm_IDEX_out,
           immSel_IDEX_out, PC_as_operand_IDEX_out, setDataZero_IDEX_out,
           addConstant4_IDEX_out, ALU_op_IDEX_out, memRead_IDEX_EXMEM,
           memWrite_IDEX_EXMEM, regWriteEnable_IDEX_EXMEM, ECALL_IDEX_EXMEM,
           memType_IDEX_EXMEM, instruction_IDEX_EXMEM, PC_IDEX_EXMEM, flush_EX,
    output stall_EX, aluResult_EXMEM, storeData_EXMEM, instruction_EXMEM,
           PC_EXMEM, memRead_EXMEM, memWrite_EXMEM, regWriteEnable_EXMEM,
           ECALL_EXMEM, memType_EXMEM
  );
endinterface

// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle ALU plus an iterative RV32M multiply/divide
// unit (one shift-add / restoring-subtract step per cycle on magnitudes,
// sign fixed up at the end). Results land in the EX/MEM register.
module ex_stage_muldiv #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          MD_STEPS  = 32
) (
  input logic              clk,
  input logic              rst_n,
  ex_stage_muldiv_if.slave bus
);
  localparam int CW = $clog2(MD_STEPS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0] count;
  logic [31:0]   op_a, op_b, alu_res, md_res, res;
  logic [31:0]   hi, lo, mag_b;
  logic [2:0]    md_op, f3;
  logic          neg_res, neg_rem, div0;
  logic          is_mop, sgn_a, sgn_b, stall;
  logic [32:0]   add_sum, rem_sh;
  logic [31:0]   div_diff, q_c, r_c;
  logic          div_ge;
  logic [63:0]   prod, prod_c;

  // Operand selection
  always_comb begin
    op_a = bus.regData1_IDEX_out;
    if (bus.PC_as_operand_IDEX_out)    op_a = bus.PC_IDEX_EXMEM;
    else if (bus.setDataZero_IDEX_out) op_a = '0;
    op_b = bus.regData2_IDEX_out;
    if (bus.addConstant4_IDEX_out)     op_b = 32'd4;
    else if (bus.immSel_IDEX_out)      op_b = bus.sext_imm_IDEX_out;
  end

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (bus.ALU_op_IDEX_out)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << op_b[4:0];
      4'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {31'b0, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> op_b[4:0];
      4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // M-op decode; signedness of each operand depends on funct3
  assign f3     = bus.instruction_IDEX_EXMEM[14:12];
  assign is_mop = (bus.instruction_IDEX_EXMEM[6:0] == 7'b0110011) &&
                  (bus.instruction_IDEX_EXMEM[31:25] == 7'b0000001);
  assign sgn_a  = op_a[31] & (f3 != 3'd3) & (f3 != 3'd5) & (f3 != 3'd7);
  assign sgn_b  = op_b[31] & ((f3 == 3'd0) | (f3 == 3'd1) | (f3 == 3'd4) | (f3 == 3'd6));

  // FSM next state and stall; flush wins over everything
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    if (bus.flush_EX) state_n = IDLE;
    else begin
      case (state)
        IDLE: if (is_mop) begin state_n = BUSY; stall = 1'b1; end
        BUSY: begin
          stall = 1'b1;
          if (count == CW'(MD_STEPS - 1)) state_n = DONE;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.stall_EX = stall & rst_n;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  // Iteration step datapath (hi:lo is product or remainder:quotient)
  assign add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : 33'd0);
  assign rem_sh   = {hi, lo[31]};
  assign div_ge   = rem_sh >= {1'b0, mag_b};
  assign div_diff = rem_sh[31:0] - mag_b;

  // Operand latch on issue, then one step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0; hi <= '0; lo <= '0; mag_b <= '0;
      md_op <= '0; neg_res <= 1'b0; neg_rem <= 1'b0; div0 <= 1'b0;
    end else if (state == IDLE && state_n == BUSY) begin
      count   <= '0;
      hi      <= '0;
      lo      <= sgn_a ? -op_a : op_a;
      mag_b   <= sgn_b ? -op_b : op_b;
      md_op   <= f3;
      neg_res <= sgn_a ^ sgn_b;
      neg_rem <= sgn_a;
      div0    <= (op_b == '0);
    end else if (state == BUSY) begin
      count <= count + 1'b1;
      if (md_op[2]) begin
        hi <= div_ge ? div_diff : rem_sh[31:0];
        lo <= {lo[30:0], div_ge};
      end else begin
        hi <= add_sum[32:1];
        lo <= {add_sum[0], lo[31:1]};
      end
    end
  end

  // Sign correction and result select; divide-by-zero forces all-ones quotient
  always_comb begin
    prod   = {hi, lo};
    prod_c = neg_res ? -prod : prod;
    q_c    = div0 ? 32'hFFFF_FFFF : (neg_res ? -lo : lo);
    r_c    = neg_rem ? -hi : hi;
    case (md_op)
      3'd0:       md_res = prod_c[31:0];
      3'd1, 3'd2,
      3'd3:       md_res = prod_c[63:32];
      3'd4, 3'd5: md_res = q_c;
      default:    md_res = r_c;
    endcase
  end

  assign res = (state == DONE) ? md_res : alu_res;

  // EX/MEM register: bubble on flush or stall, else capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush_EX || stall) begin
      bus.aluResult_EXMEM      <= '0;
      bus.storeData_EXMEM      <= '0;
      bus.instruction_EXMEM    <= NOP_INSTR;
      bus.PC_EXMEM             <= '0;
      bus.memRead_EXMEM        <= 1'b0;
      bus.memWrite_EXMEM       <= 1'b0;
      bus.regWriteEnable_EXMEM <= 1'b0;
      bus.ECALL_EXMEM          <= 1'b0;
      bus.memType_EXMEM        <= '0;
    end else begin
      bus.aluResult_EXMEM      <= res;
      bus.storeData_EXMEM      <= bus.regData2_IDEX_out;
      bus.instruction_EXMEM    <= bus.instruction_IDEX_EXMEM;
      bus.PC_EXMEM             <= bus.PC_IDEX_EXMEM;
      bus.memRead_EXMEM        <= bus.memRead_IDEX_EXMEM;
      bus.memWrite_EXMEM       <= bus.memWrite_IDEX_EXMEM;
      bus.regWriteEnable_EXMEM <= bus.regWriteEnable_IDEX_EXMEM;
      bus.ECALL_EXMEM          <= bus.ECALL_IDEX_EXMEM;
      bus.memType_EXMEM        <= bus.memType_IDEX_EXMEM;
    end
  end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: the driver pushes the expected
// EX/MEM contents when it issues an instruction, the monitor pops and
// compares whenever EX/MEM holds a register-writing (non-bubble) entry.
module tb_ex_stage_muldiv;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_muldiv_if bus_if ();
  ex_stage_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  typedef struct {
    logic [31:0] r1, r2, imm, pc, instr;
    logic        isel, pcop, zero, c4;
    logic [3:0]  op;
    logic        mr, mw, ecall;
    logic [2:0]  mt;
  } stim_t;

  typedef struct {
    logic [31:0] res, store, instr, pc;
    logic        mr, mw, ecall;
    logic [2:0]  mt;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference model straight from the instruction-set rules
  function automatic logic [31:0] model(input stim_t s);
    logic [31:0] a, b;
    longint      p;
    longint unsigned up;
    int          ia, ib;
    a = s.pcop ? s.pc : (s.zero ? 32'd0 : s.r1);
    b = s.c4 ? 32'd4 : (s.isel ? s.imm : s.r2);
    ia = $signed(a);
    ib = $signed(b);
    if (s.instr[6:0] == 7'h33 && s.instr[31:25] == 7'h01) begin
      case (s.instr[14:12])
        3'd0: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
        3'd1: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
        3'd2: begin p = longint'(ia) * longint'({32'd0, b}); return p[63:32]; end
        3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
        3'd4: if (b == 0) return 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
              else return ia / ib;
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: if (b == 0) return a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
              else return ia % ib;
        default: return (b == 0) ? a : a % b;
      endcase
    end
    case (s.op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return (ia < ib) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return ia >>> b[4:0];
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic stim_t mk_alu(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2);
    stim_t s;
    s.r1 = r1; s.r2 = r2; s.imm = 32'd0; s.pc = 32'h1000;
    s.instr = {25'h0000_0A5, 7'b0010011};
    s.isel = 1'b0; s.pcop = 1'b0; s.zero = 1'b0; s.c4 = 1'b0;
    s.op = op; s.mr = 1'b0; s.mw = 1'b0; s.ecall = 1'b0; s.mt = 3'd2;
    return s;
  endfunction

  function automatic stim_t mk_m(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2);
    stim_t s;
    s = mk_alu(4'd0, r1, r2);
    s.instr = {7'b0000001, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
    s.pc = 32'h2000 + {29'd0, f3};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus_if.regData1_IDEX_out         = s.r1;
    bus_if.regData2_IDEX_out         = s.r2;
    bus_if.sext_imm_IDEX_out         = s.imm;
    bus_if.immSel_IDEX_out           = s.isel;
    bus_if.PC_as_operand_IDEX_out    = s.pcop;
    bus_if.setDataZero_IDEX_out      = s.zero;
    bus_if.addConstant4_IDEX_out     = s.c4;
    bus_if.ALU_op_IDEX_out           = s.op;
    bus_if.memRead_IDEX_EXMEM        = s.mr;
    bus_if.memWrite_IDEX_EXMEM       = s.mw;
    bus_if.regWriteEnable_IDEX_EXMEM = 1'b1;
    bus_if.ECALL_IDEX_EXMEM          = s.ecall;
    bus_if.memType_IDEX_EXMEM        = s.mt;
    bus_if.instruction_IDEX_EXMEM    = s.instr;
    bus_if.PC_IDEX_EXMEM             = s.pc;
  endtask

  task automatic bubble();
    bus_if.regWriteEnable_IDEX_EXMEM = 1'b0;
    bus_if.memRead_IDEX_EXMEM        = 1'b0;
    bus_if.memWrite_IDEX_EXMEM       = 1'b0;
    bus_if.ECALL_IDEX_EXMEM          = 1'b0;
    bus_if.instruction_IDEX_EXMEM    = NOP;
  endtask

  // Issue one instruction, hold it while stalled, count stall cycles
  task automatic issue(input stim_t s, input bit use_k, input logic [31:0] k, output int stalls);
    exp_t e;
    logic st;
    bit   ok;
    e.res = use_k ? k : model(s);
    e.store = s.r2; e.instr = s.instr; e.pc = s.pc;
    e.mr = s.mr; e.mw = s.mw; e.ecall = s.ecall; e.mt = s.mt;
    q.push_back(e);
    apply(s);
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      st = bus_if.stall_EX;
      if (st) stalls++;
      @(posedge clk);
      #1;
      if (!st) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    bubble();
  endtask

  // Monitor: every register-writing EX/MEM entry must match the queue head
  always @(negedge clk) begin
    if (rst_n && bus_if.regWriteEnable_EXMEM) begin
      if (q.size() == 0) chk("unexpected_result", bus_if.instruction_EXMEM, NOP);
      else begin
        me = q.pop_front();
        chk("result", bus_if.aluResult_EXMEM, me.res);
        chk("store",  bus_if.storeData_EXMEM, me.store);
        chk("instr",  bus_if.instruction_EXMEM, me.instr);
        chk("pc",     bus_if.PC_EXMEM, me.pc);
        chk("ctl", {26'd0, bus_if.memRead_EXMEM, bus_if.memWrite_EXMEM,
                    bus_if.ECALL_EXMEM, bus_if.memType_EXMEM},
                   {26'd0, me.mr, me.mw, me.ecall, me.mt});
      end
    end
  end

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_stall"}, {31'd0, bus_if.stall_EX}, 32'd0);
    chk({tag, "_instr"}, bus_if.instruction_EXMEM, NOP);
    chk({tag, "_res"},   bus_if.aluResult_EXMEM, 32'd0);
    chk({tag, "_pc"},    bus_if.PC_EXMEM, 32'd0);
    chk({tag, "_ctl"},   {27'd0, bus_if.regWriteEnable_EXMEM, bus_if.memRead_EXMEM,
                          bus_if.memWrite_EXMEM, bus_if.ECALL_EXMEM, 1'b0}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    int    st;
    bubble();
    bus_if.flush_EX = 1'b0;
    apply(mk_alu(4'd0, 0, 0));
    bubble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed ALU cases
    s = mk_alu(4'd0, 32'd5, 32'd7);
    issue(s, 1, 32'd12, st); chk("add_stall", 32'(st), 32'd0);
    s = mk_alu(4'd0, 32'd9, 32'd9); s.pcop = 1; s.isel = 1; s.pc = 32'h100; s.imm = 32'h2000;
    issue(s, 1, 32'h2100, st);
    s = mk_alu(4'd0, 32'd9, 32'd9); s.pcop = 1; s.c4 = 1; s.pc = 32'h40;
    issue(s, 1, 32'h44, st);
    s = mk_alu(4'd7, 32'h8000_0000, 32'd0); s.isel = 1; s.imm = 32'd4;
    issue(s, 1, 32'hF800_0000, st);

    // Directed M-ops
    issue(mk_m(3'd0, -32'sd3, 32'd7), 1, 32'hFFFF_FFEB, st); chk("mul_stall", 32'(st), 32'd33);
    issue(mk_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1, 32'hFFFF_FFFE, st);
    issue(mk_m(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1, 32'd0, st);
    issue(mk_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 1, 32'h8000_0000, st);
    issue(mk_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 1, 32'd0, st);
    issue(mk_m(3'd5, 32'd10, 32'd0), 1, 32'hFFFF_FFFF, st);
    issue(mk_m(3'd7, 32'd10, 32'd0), 1, 32'd10, st);
    issue(mk_m(3'd4, -32'sd7, 32'd2), 1, 32'hFFFF_FFFD, st);
    issue(mk_m(3'd6, -32'sd7, 32'd2), 1, 32'hFFFF_FFFF, st);
    chk("div_stall", 32'(st), 32'd33);

    // Flush at BUSY count 10
    apply(mk_m(3'd0, 32'd123, 32'd456));
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 bus_if.flush_EX = 1'b1;
    #1 chk("flush_stall_drop", {31'd0, bus_if.stall_EX}, 32'd0);
    @(posedge clk); #1 bus_if.flush_EX = 1'b0; bubble();
    @(negedge clk);
    chk("flush_instr", bus_if.instruction_EXMEM, NOP);
    chk("flush_ctl", {29'd0, bus_if.regWriteEnable_EXMEM, bus_if.memRead_EXMEM,
                      bus_if.memWrite_EXMEM}, 32'd0);
    @(posedge clk); #1;
    issue(mk_alu(4'd0, 32'd20, 32'd22), 1, 32'd42, st); chk("post_flush_stall", 32'(st), 32'd0);

    // Reset in the middle of a divide
    apply(mk_m(3'd4, 32'd1000, 32'd3));
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_state("mid_reset");
    bubble();
    @(posedge clk); #1 rst_n = 1'b1;
    issue(mk_m(3'd4, 32'd100, 32'd7), 1, 32'd14, st); chk("div_after_reset_stall", 32'(st), 32'd33);

    // Randomized mix, back-to-back
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        s = mk_m(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      end else begin
        s = mk_alu(4'($urandom_range(0, 15)), rnd_val(), rnd_val());
        s.imm = rnd_val(); s.pc = $urandom;
        s.instr = {$urandom_range(1, 32'h1FF_FFFF) | 32'h1, 7'b0010011};
        s.isel = 1'($urandom); s.pcop = 1'($urandom);
        s.zero = 1'($urandom); s.c4 = 1'($urandom);
      end
      s.mr = 1'($urandom); s.mw = 1'($urandom); s.ecall = 1'($urandom);
      s.mt = 3'($urandom);
      issue(s, 0, 32'd0, st);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
